// File: rtl/dmem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_pkg: shared types and constants for the data-RAM arbiter   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package dmem_pkg;

  localparam int   WORD_W    = 32;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_NORMAL    = 2'd0,
    ST_LOCK_PEND = 2'd1,
    ST_LOCKED    = 2'd2
  } dmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_prio_sel.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_prio_sel: combinational CPU/debug winner select            |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module dmem_prio_sel
  import dmem_pkg::*;
#(
  parameter int CNT_W      = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic             cpu_req,
  input  logic             dbg_req,
  input  dmem_state_e      state,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             cpu_win,
  output logic             dbg_win
);

  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    case (state)
      ST_NORMAL: begin
        // CPU has priority until it has won STARVE_MAX contested cycles in a row
        if (cpu_req && dbg_req && (starve_cnt == CNT_W'(STARVE_MAX))) begin
          dbg_win = 1'b1;
        end else if (cpu_req) begin
          cpu_win = 1'b1;
        end else begin
          dbg_win = dbg_req;
        end
      end
      ST_LOCKED: dbg_win = dbg_req;
      default: begin
        cpu_win = 1'b0;
        dbg_win = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_arbiter: shares the data RAM between CPU and debug ports   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [3:0]            cpu_be,
  input  logic [WORD_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [WORD_W-1:0]     dbg_addr,
  input  logic [WORD_W-1:0]     dbg_wdata,
  input  logic                  dbg_lock,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [WORD_W-1:0]     dbg_rdata,
  output logic                  dbg_err,
  output logic                  dbg_locked,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [WORD_W-1:0]     mem_wdata,
  input  logic [WORD_W-1:0]     mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  dmem_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_starve_cnt, w_starve_nxt;
  logic             r_rd_pend, r_rd_owner, r_rd_err;
  logic             w_cpu_win, w_dbg_win, w_cpu_gnt, w_dbg_gnt;
  logic             w_cpu_oor, w_dbg_oor, w_win_oor, w_win_we;
  logic             w_unused_addr_lsbs;

  dmem_prio_sel #(
    .CNT_W      (CNT_W),
    .STARVE_MAX (STARVE_MAX)
  ) u_prio_sel (
    .cpu_req    (cpu_req),
    .dbg_req    (dbg_req),
    .state      (r_state),
    .starve_cnt (r_starve_cnt),
    .cpu_win    (w_cpu_win),
    .dbg_win    (w_dbg_win)
  );

  // No grants are issued while reset is held
  assign w_cpu_gnt = w_cpu_win & reset;
  assign w_dbg_gnt = w_dbg_win & reset;

  assign w_cpu_oor = |cpu_addr[WORD_W-1:DEPTH_LOG2+2];
  assign w_dbg_oor = |dbg_addr[WORD_W-1:DEPTH_LOG2+2];
  assign w_win_oor = w_dbg_gnt ? w_dbg_oor : w_cpu_oor;
  assign w_win_we  = w_dbg_gnt ? dbg_we : cpu_we;
  assign w_unused_addr_lsbs = ^{cpu_addr[1:0], dbg_addr[1:0]};

  assign mem_en    = (w_cpu_gnt | w_dbg_gnt) & ~w_win_oor;
  assign mem_we    = mem_en & w_win_we;
  assign mem_be    = w_dbg_gnt ? 4'hF : cpu_be;
  assign mem_addr  = w_dbg_gnt ? dbg_addr[DEPTH_LOG2+1:2] : cpu_addr[DEPTH_LOG2+1:2];
  assign mem_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;

  assign cpu_gnt    = w_cpu_gnt;
  assign cpu_stall  = cpu_req & ~w_cpu_gnt;
  assign cpu_rvalid = r_rd_pend & (r_rd_owner == OWNER_CPU);
  assign cpu_rdata  = (cpu_rvalid & ~r_rd_err) ? mem_rdata : '0;
  assign cpu_err    = (cpu_rvalid & r_rd_err) | (w_cpu_gnt & cpu_we & w_cpu_oor);

  assign dbg_gnt    = w_dbg_gnt;
  assign dbg_rvalid = r_rd_pend & (r_rd_owner == OWNER_DBG);
  assign dbg_rdata  = (dbg_rvalid & ~r_rd_err) ? mem_rdata : '0;
  assign dbg_err    = (dbg_rvalid & r_rd_err) | (w_dbg_gnt & dbg_we & w_dbg_oor);
  assign dbg_locked = (r_state == ST_LOCKED);

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = '0;
    case (r_state)
      ST_NORMAL: begin
        if (dbg_lock) w_state_nxt = ST_LOCK_PEND;
        if (cpu_req && dbg_req && !w_dbg_win) w_starve_nxt = r_starve_cnt + CNT_W'(1);
      end
      ST_LOCK_PEND: begin
        // Let an outstanding CPU load drain before debug takes the RAM
        if (!dbg_lock)        w_state_nxt = ST_NORMAL;
        else if (!cpu_rvalid) w_state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!dbg_lock) w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_NORMAL;
      r_starve_cnt <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWNER_CPU;
      r_rd_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      r_rd_pend    <= (w_cpu_gnt & ~cpu_we) | (w_dbg_gnt & ~dbg_we);
      r_rd_owner   <= w_dbg_gnt ? OWNER_DBG : OWNER_CPU;
      r_rd_err     <= w_win_oor;
    end
  end

endmodule
`default_nettype wire
